// File: rtl/lcd_write_sequencer.sv
// HD44780 character-LCD write sequencer: RS/DATA setup, E strobe and execution wait from one 23-bit timer.
// Define LCD_SEQ_INIT_EN to run the power-on wait and the 8-bit init ROM after every reset.
module lcd_write_sequencer #(
   parameter int unsigned T_AS    = 3,
   parameter int unsigned T_PW    = 13,
   parameter int unsigned T_EXEC  = 2100,
   parameter int unsigned T_CLR   = 82000,
   parameter int unsigned T_PWRON = 2000000,
   parameter int unsigned T_INIT1 = 205000,
   parameter int unsigned T_INIT2 = 5000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       wr_req,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   output logic       busy,
   output logic       init_done,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA,
   output logic       LCD_E
);

   localparam logic [22:0] AS_LAST    = 23'(T_AS - 1);
   localparam logic [22:0] PW_LAST    = 23'(T_PW - 1);
   localparam logic [22:0] EXEC_LAST  = 23'(T_EXEC - 1);
   localparam logic [22:0] CLR_LAST   = 23'(T_CLR - 1);
   localparam logic [22:0] PWRON_LAST = 23'(T_PWRON - 1);
   localparam logic [22:0] INIT1_LAST = 23'(T_INIT1 - 1);
   localparam logic [22:0] INIT2_LAST = 23'(T_INIT2 - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      S_WAIT  = 3'd3
`ifdef LCD_SEQ_INIT_EN
      ,
      S_PWRON = 3'd4,
      S_LOAD  = 3'd5
`endif
   } state_t;

   typedef enum logic [1:0] {
      W_EXEC  = 2'd0,
      W_CLR   = 2'd1,
      W_INIT1 = 2'd2,
      W_INIT2 = 2'd3
   } wait_t;

   state_t      state_q, state_d;
   wait_t       wait_q, wait_d;
   logic [22:0] count_q, count_d;
   logic [22:0] last_count;
   logic        timer_done;
   logic        ack_q, ack_d;
   logic        busy_q, busy_d;
   logic        init_done_q, init_done_d;
   logic        rs_q, rs_d;
   logic [7:0]  data_q, data_d;
   logic        e_q, e_d;

`ifdef LCD_SEQ_INIT_EN
   logic [2:0]  rom_idx_q, rom_idx_d;
   logic [7:0]  rom_data;
   wait_t       rom_wait;

   always_comb begin
      rom_data = 8'h38;
      rom_wait = W_EXEC;
      unique case (rom_idx_q)
         3'd0:    rom_wait = W_INIT1;
         3'd1:    rom_wait = W_INIT2;
         3'd4:    rom_data = 8'h0C;
         3'd5:    begin rom_data = 8'h01; rom_wait = W_CLR; end
         3'd6:    rom_data = 8'h06;
         default: rom_data = 8'h38;
      endcase
   end
`endif

   // The terminal count depends on the state; IDLE shares the PWRON slot since its timer is unused.
   always_comb begin
      last_count = PWRON_LAST;
      unique case (state_q)
         S_SETUP: last_count = AS_LAST;
         S_PULSE: last_count = PW_LAST;
         S_WAIT: begin
            unique case (wait_q)
               W_EXEC:  last_count = EXEC_LAST;
               W_CLR:   last_count = CLR_LAST;
               W_INIT1: last_count = INIT1_LAST;
               default: last_count = INIT2_LAST;
            endcase
         end
         default: last_count = PWRON_LAST;
      endcase
   end

   assign timer_done = (count_q == last_count);

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      count_d     = count_q + 23'd1;
      ack_d       = 1'b0;
      busy_d      = busy_q;
      init_done_d = init_done_q;
      rs_d        = rs_q;
      data_d      = data_q;
      e_d         = e_q;
`ifdef LCD_SEQ_INIT_EN
      rom_idx_d   = rom_idx_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            count_d = '0;
            // IDLE acts as the LOAD cycle for user writes so RS/DATA change together with the ack.
            if (wr_req && init_done_q) begin
               ack_d   = 1'b1;
               busy_d  = 1'b1;
               rs_d    = wr_rs;
               data_d  = wr_data;
               wait_d  = (!wr_rs && (wr_data inside {8'h01, 8'h02, 8'h03})) ? W_CLR : W_EXEC;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (timer_done) begin
               count_d = '0;
               e_d     = 1'b1;
               state_d = S_PULSE;
            end
         end
         S_PULSE: begin
            if (timer_done) begin
               count_d = '0;
               e_d     = 1'b0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (timer_done) begin
               count_d = '0;
`ifdef LCD_SEQ_INIT_EN
               if (!init_done_q && rom_idx_q != 3'd6) begin
                  rom_idx_d = rom_idx_q + 3'd1;
                  state_d   = S_LOAD;
               end else begin
                  init_done_d = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = S_IDLE;
               end
`else
               busy_d  = 1'b0;
               state_d = S_IDLE;
`endif
            end
         end
`ifdef LCD_SEQ_INIT_EN
         S_PWRON: begin
            if (timer_done) begin
               count_d = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            count_d = '0;
            rs_d    = 1'b0;
            data_d  = rom_data;
            wait_d  = rom_wait;
            state_d = S_SETUP;
         end
`endif
         default: begin
            count_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
`ifdef LCD_SEQ_INIT_EN
         state_q     <= S_PWRON;
         busy_q      <= 1'b1;
         init_done_q <= 1'b0;
         rom_idx_q   <= 3'd0;
`else
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         init_done_q <= 1'b1;
`endif
         wait_q      <= W_EXEC;
         count_q     <= '0;
         ack_q       <= 1'b0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         e_q         <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         init_done_q <= init_done_d;
`ifdef LCD_SEQ_INIT_EN
         rom_idx_q   <= rom_idx_d;
`endif
         wait_q      <= wait_d;
         count_q     <= count_d;
         ack_q       <= ack_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
         e_q         <= e_d;
      end
   end

   assign wr_ack    = ack_q;
   assign busy      = busy_q;
   assign init_done = init_done_q;
   assign LCD_RS    = rs_q;
   assign LCD_RW    = 1'b0;
   assign LCD_DATA  = data_q;
   assign LCD_E     = e_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed self-checking bench for lcd_write_sequencer; expectations adapt to LCD_SEQ_INIT_EN.
module tb_lcd_write_sequencer;

   localparam int T_AS    = 3;
   localparam int T_PW    = 13;
   localparam int T_EXEC  = 4;
   localparam int T_CLR   = 8;
   localparam int T_PWRON = 20;
   localparam int T_INIT1 = 10;
   localparam int T_INIT2 = 5;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       wr_req = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ack, busy, init_done, LCD_RS, LCD_RW, LCD_E;
   logic [7:0] LCD_DATA;

   int assertCount = 0;
   int failCount = 0;
   int cyc = 0;
   int riseQ[$];
   int fallQ[$];
   int ackQ[$];
   logic [7:0] riseData[$];
   logic riseRs[$];
   int ackWhileBusy = 0;
   int dataGlitch = 0;
   int initDoneCyc = -1;
   logic prevE = 1'b0, prevBusy = 1'b0, prevInitDone = 1'b0, prevRs = 1'b0;
   logic [7:0] prevData = 8'h00;

   lcd_write_sequencer #(
      .T_AS(T_AS), .T_PW(T_PW), .T_EXEC(T_EXEC), .T_CLR(T_CLR),
      .T_PWRON(T_PWRON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2)
   ) dut (
      .CLK(CLK), .RST(RST), .wr_req(wr_req), .wr_rs(wr_rs), .wr_data(wr_data),
      .wr_ack(wr_ack), .busy(busy), .init_done(init_done),
      .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA), .LCD_E(LCD_E)
   );

   always #10 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Bus monitor: logs E edges, acks and init completion by edge number, and flags bus changes under E.
   always @(negedge CLK) begin
      if (LCD_E && !prevE) begin
         riseQ.push_back(cyc);
         riseData.push_back(LCD_DATA);
         riseRs.push_back(LCD_RS);
      end
      if (!LCD_E && prevE) fallQ.push_back(cyc);
      if (LCD_E && prevE && (LCD_DATA != prevData || LCD_RS != prevRs)) dataGlitch++;
      if (wr_ack) begin
         ackQ.push_back(cyc);
         if (prevBusy) ackWhileBusy++;
      end
      if (init_done && !prevInitDone) initDoneCyc = cyc;
      prevE        = LCD_E;
      prevBusy     = busy;
      prevInitDone = init_done;
      prevRs       = LCD_RS;
      prevData     = LCD_DATA;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic rs, input logic [7:0] data);
      wr_rs   = rs;
      wr_data = data;
      wr_req  = 1'b1;
   endtask

   task automatic waitAck(output int ackCyc, input logic dropReq);
      ackCyc = -1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (wr_ack) begin
            ackCyc = cyc;
            if (dropReq) wr_req = 1'b0;
            return;
         end
      end
      checkOutput("ack timeout", 0, 1);
      wr_req = 1'b0;
   endtask

   task automatic waitBusyLow(output int lowCyc);
      lowCyc = -1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (!busy) begin
            lowCyc = cyc;
            return;
         end
      end
      checkOutput("busy timeout", 0, 1);
   endtask

   task automatic checkWrite(input string tag, input logic rs, input logic [7:0] data, input int expWait,
                             input int r0, input int f0, input int n0, input int ackCyc);
      int lowCyc;
      waitBusyLow(lowCyc);
      @(negedge CLK);
      checkOutput({tag, " pulses"}, riseQ.size() - r0, 1);
      checkOutput({tag, " ack cycles"}, ackQ.size() - n0, 1);
      if (riseQ.size() > r0 && fallQ.size() > f0) begin
         checkOutput({tag, " rs"}, riseRs[r0], rs);
         checkOutput({tag, " data"}, riseData[r0], data);
         checkOutput({tag, " setup"}, riseQ[r0] - ackCyc, T_AS);
         checkOutput({tag, " width"}, fallQ[f0] - riseQ[r0], T_PW);
         checkOutput({tag, " wait"}, lowCyc - fallQ[f0], expWait);
      end
   endtask

   task automatic writeAndCheck(input string tag, input logic rs, input logic [7:0] data, input int expWait);
      int r0, f0, n0, a;
      r0 = riseQ.size();
      f0 = fallQ.size();
      n0 = ackQ.size();
      applyStimulus(rs, data);
      waitAck(a, 1'b1);
      checkWrite(tag, rs, data, expWait, r0, f0, n0, a);
   endtask

`ifdef LCD_SEQ_INIT_EN
   task automatic checkInit(input int r0, input int f0, input int relCyc);
      logic [7:0] expData [7];
      int expWait [7];
      expData = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      expWait = '{T_INIT1, T_INIT2, T_EXEC, T_EXEC, T_EXEC, T_CLR, T_EXEC};
      checkOutput("init pulse count", riseQ.size() - r0, 7);
      if (riseQ.size() - r0 >= 7 && fallQ.size() - f0 >= 7) begin
         checkOutput("init first rise", riseQ[r0] - relCyc, T_PWRON + 1 + T_AS);
         for (int i = 0; i < 7; i++) begin
            checkOutput("init data", riseData[r0 + i], expData[i]);
            checkOutput("init rs", riseRs[r0 + i], 0);
            checkOutput("init width", fallQ[f0 + i] - riseQ[r0 + i], T_PW);
            if (i < 6) checkOutput("init gap", riseQ[r0 + i + 1] - fallQ[f0 + i], expWait[i] + 1 + T_AS);
         end
         checkOutput("init_done rise", initDoneCyc - fallQ[f0 + 6], T_EXEC);
      end
   endtask
`endif

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " E"}, LCD_E, 0);
      checkOutput({tag, " RS"}, LCD_RS, 0);
      checkOutput({tag, " RW"}, LCD_RW, 0);
      checkOutput({tag, " DATA"}, LCD_DATA, 8'h00);
      checkOutput({tag, " ack"}, wr_ack, 0);
`ifdef LCD_SEQ_INIT_EN
      checkOutput({tag, " busy"}, busy, 1);
      checkOutput({tag, " init_done"}, init_done, 0);
`else
      checkOutput({tag, " busy"}, busy, 0);
      checkOutput({tag, " init_done"}, init_done, 1);
`endif
   endtask

   task automatic burstWrite();
      logic [7:0] bytes [3];
      int a [3];
      int n0, r0, g0, wb0, lowCyc;
      bytes = '{8'h48, 8'h49, 8'h4A};
      n0  = ackQ.size();
      r0  = riseQ.size();
      g0  = dataGlitch;
      wb0 = ackWhileBusy;
      applyStimulus(1'b1, bytes[0]);
      for (int k = 0; k < 3; k++) begin
         waitAck(a[k], k == 2);
         if (k < 2) wr_data = bytes[k + 1];
      end
      waitBusyLow(lowCyc);
      repeat (3) @(negedge CLK);
      checkOutput("burst acks", ackQ.size() - n0, 3);
      checkOutput("burst ack while busy", ackWhileBusy - wb0, 0);
      checkOutput("burst period 1", a[1] - a[0], T_AS + T_PW + T_EXEC + 1);
      checkOutput("burst period 2", a[2] - a[1], T_AS + T_PW + T_EXEC + 1);
      checkOutput("burst data stable under E", dataGlitch - g0, 0);
      checkOutput("burst pulses", riseQ.size() - r0, 3);
      if (riseQ.size() - r0 >= 3) begin
         for (int k = 0; k < 3; k++) checkOutput("burst data", riseData[r0 + k], bytes[k]);
      end
   endtask

   initial begin
      int relCyc, a, r0, f0, n0, t;
      #2 RST = 1'b1;
      applyStimulus(1'b1, 8'h41);
      repeat (3) @(negedge CLK);
      checkResetValues("reset");
      r0 = riseQ.size();
      f0 = fallQ.size();
      n0 = ackQ.size();
      RST = 1'b0;
      relCyc = cyc;
      waitAck(a, 1'b1);
`ifdef LCD_SEQ_INIT_EN
      checkInit(r0, f0, relCyc);
      checkOutput("held request served after init", a, initDoneCyc + 1);
      r0 = r0 + 7;
      f0 = f0 + 7;
`else
      checkOutput("first IDLE edge ack", a, relCyc + 1);
`endif
      checkWrite("data 41", 1'b1, 8'h41, T_EXEC, r0, f0, n0, a);

      writeAndCheck("cmd 01", 1'b0, 8'h01, T_CLR);
      writeAndCheck("cmd 02", 1'b0, 8'h02, T_CLR);
      writeAndCheck("cmd 03", 1'b0, 8'h03, T_CLR);
      writeAndCheck("cmd 80", 1'b0, 8'h80, T_EXEC);
      writeAndCheck("cmd 04", 1'b0, 8'h04, T_EXEC);
      writeAndCheck("data 01", 1'b1, 8'h01, T_EXEC);

      burstWrite();

      // Reset in the middle of an E pulse must drop the strobe without a clock edge.
      applyStimulus(1'b1, 8'h55);
      waitAck(a, 1'b1);
      t = 0;
      while (!LCD_E && t < 100) begin
         @(negedge CLK);
         t++;
      end
      checkOutput("E high before reset", LCD_E, 1);
      #3 RST = 1'b1;
      #1 checkResetValues("async reset");
      repeat (3) @(negedge CLK);
      #1;
      r0 = riseQ.size();
      f0 = fallQ.size();
      RST = 1'b0;
      relCyc = cyc;
`ifdef LCD_SEQ_INIT_EN
      t = 0;
      while (!init_done && t < 3000) begin
         @(negedge CLK);
         t++;
      end
      checkOutput("init_done after reset", init_done, 1);
      @(negedge CLK);
      checkInit(r0, f0, relCyc);
`else
      writeAndCheck("after reset", 1'b1, 8'h5A, T_EXEC);
`endif
      writeAndCheck("final cmd 80", 1'b0, 8'h80, T_EXEC);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/lcd_write_sequencer.md
# lcd_write_sequencer

Sequences all byte writes to the character LCD on the C5G temperature-display path. After reset it runs the HD44780 8-bit power-on initialisation. It then accepts command/data bytes from the display formatter over a request/acknowledge handshake, and generates RS/DATA setup, the LCD_E pulse and the per-command execution wait from a single internal 23-bit timer. The block replaces the ad-hoc per-state enable/delay sequencing and is the only driver of the LCD bus pins.

## Interface
- T_AS, 3, RS/DATA setup cycles before LCD_E rises (60 ns at 50 MHz)
- T_PW, 13, LCD_E high cycles (260 ns)
- T_EXEC, 2100, post-pulse wait for normal commands/data (42 us)
- T_CLR, 82000, post-pulse wait for clear/home commands (1640 us)
- T_PWRON, 2000000, wait after reset before the first init write (40 ms)
- T_INIT1, 205000, wait after the first init function set (4100 us)
- T_INIT2, 5000, wait after the second init function set (100 us)
- CLK  in  1  system clock, 50 MHz
- RST  in  1  asynchronous, active-high reset
- wr_req  in  1  write request (level), held until wr_ack
- wr_rs  in  1  0 = command, 1 = data; valid with wr_req
- wr_data  in  8  byte to write; valid with wr_req
- wr_ack  out  1  one-cycle pulse: request captured
- busy  out  1  high while the sequencer cannot accept a request
- init_done  out  1  high once initialisation has completed; stays high until reset
- LCD_RS  out  1  register select
- LCD_RW  out  1  constant 0 (write only)
- LCD_DATA  out  8  LCD data bus
- LCD_E  out  1  LCD enable strobe

## Operation
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00, wr_ack=0.
- With LCD_SEQ_INIT_EN: busy=1 and init_done=0 at reset. Without it: busy=0 and init_done=1.
- States:
  - PWRON: counts T_PWRON, then goes to LOAD.
  - LOAD: drives RS/DATA from the init ROM or the captured request.
  - SETUP: counts T_AS, then raises E.
  - PULSE: counts T_PW, then drops E.
  - WAIT: counts the selected wait, then goes to IDLE or the next ROM entry.
  - IDLE: waits for a request.
- Init ROM, all RS=0, sent in order:
  - 8'h38, then wait T_INIT1
  - 8'h38, then wait T_INIT2
  - 8'h38, 8'h38, 8'h0C, each then T_EXEC
  - 8'h01, then T_CLR
  - 8'h06, then T_EXEC
  - After the last entry: init_done=1, busy=0, go to IDLE.
- Wait selection for user writes: RS=0 and data in {8'h01, 8'h02, 8'h03} uses T_CLR; all other writes use T_EXEC.
- Timer: 23-bit up-counter, cleared on every state entry. A state ends when count == param-1. Every parameter must be in the range 1..2^23-1.
- wr_req is ignored in every state except IDLE, and ignored entirely while init_done=0. A requester holding wr_req while busy is neither lost nor acknowledged; it is served on return to IDLE.
- LCD_RS and LCD_DATA hold the last written value until the next LOAD.
- Asynchronous RST at any point: outputs take their reset values immediately (E drops mid-pulse), and the sequence restarts at PWRON or IDLE according to the macro.

## Timing
- Request sampled in IDLE at edge N:
  - Edge N: wr_ack=1 for exactly one cycle, busy=1, LCD_RS/LCD_DATA updated. IDLE doubles as LOAD for user writes.
  - Edge N+T_AS: LCD_E rises.
  - Edge N+T_AS+T_PW: LCD_E falls.
  - Edge N+T_AS+T_PW+Twait: busy=0, back in IDLE.
- Earliest next acceptance is the edge after busy falls. Back-to-back period is T_AS+T_PW+Twait+1 cycles.
- Init writes follow the same SETUP/PULSE/WAIT cadence, with one LOAD cycle before each SETUP.
- LCD_RS and LCD_DATA never change while LCD_E=1.

## Configuration
- LCD_SEQ_INIT_EN defined: PWRON and the init ROM sequence run after every reset, as described above.
- LCD_SEQ_INIT_EN undefined: PWRON and the ROM logic are compiled out. The block comes out of reset in IDLE with init_done=1, and the formatter is responsible for issuing the init commands itself.

## Test plan
- Reset/init, with overrides T_PWRON=20, T_INIT1=10, T_INIT2=5, T_EXEC=4, T_CLR=8 and INIT_EN defined:
  - Required: exactly 7 E pulses with data 38,38,38,38,0C,01,06.
  - Required: the gap from E fall to the next E rise equals the selected wait+1+T_AS.
  - Required: init_done rises after the 06 wait.
- Data write, wr_rs=1, wr_data=8'h41 in IDLE:
  - Required: wr_ack pulses one cycle; RS=1, DATA=41.
  - Required: E high for exactly T_PW cycles, starting T_AS cycles after ack.
  - Required: busy drops T_EXEC cycles after E falls.
- Clear command, wr_rs=0, wr_data=8'h01: busy stays high T_CLR cycles after E falls. Repeat with 8'h80: T_EXEC cycles.
- wr_req held high continuously with 3 queued bytes:
  - Required: 3 acks, with no ack while busy=1.
  - Required: DATA is stable throughout every E-high window.
- RST asserted mid-PULSE: E drops to 0 in the same cycle without waiting for a clock, and the sequence restarts from PWRON.
- INIT_EN undefined: init_done=1 and busy=0 directly out of reset; the first request is accepted on the first IDLE edge.
